// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller and its alignment helper.
// Contents: funct3 access-size encodings, FSM state encoding, timeout counter width.
// Imported by mem_align_unit and mem_stage_ctrl.
package mem_stage_ctrl_pkg;

  // funct3 encodings for load/store access size and signedness
  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU (load only)
  localparam logic [2:0] F3_HU = 3'b101;  // LHU (load only)

  // Timeout counter width; covers TIMEOUT_CYCLES up to 255
  localparam int unsigned TMO_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for an M-stage access
    WAIT = 2'd1,  // request outstanding on the data bus
    DONE = 2'd2   // one unstalled cycle so the instruction reaches MEM/WB
  } mem_state_e;

  // True for the encodings that a store may legally use
  function automatic logic f3_store_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the M-stage controller and memory.
// Ports: master drives req/we/addr/be/wdata, slave returns a one-cycle ack with rdata.
// Request is held (with all other master signals stable) until ack is seen.
interface mem_stage_ctrl_if;

  logic        dmem_req;    // bus request, held until ack
  logic        dmem_we;     // 1 = write
  logic [31:0] dmem_addr;   // word-aligned address
  logic [3:0]  dmem_be;     // byte enables
  logic [31:0] dmem_wdata;  // lane-replicated store data
  logic        dmem_ack;    // one-cycle completion
  logic [31:0] dmem_rdata;  // read word, valid with ack

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_align_unit.sv
// Byte-lane alignment for load/store: lane enables, store replication, load extension.
// Ports: off_i/funct3_i/is_store_i/rs2_i/rdata_i in; be_o/wdata_o/ld_data_o/misaligned_o out.
// Purely combinational, no handshake.
module mem_align_unit
  import mem_stage_ctrl_pkg::*;
(
  input  logic [1:0]  off_i,         // byte offset within the word
  input  logic [2:0]  funct3_i,      // access size / signedness
  input  logic        is_store_i,    // 1 = store access
  input  logic [31:0] rs2_i,         // raw store data
  input  logic [31:0] rdata_i,       // raw word read from memory
  output logic [3:0]  be_o,          // byte enables
  output logic [31:0] wdata_o,       // replicated store data
  output logic [31:0] ld_data_o,     // extended load result
  output logic        misaligned_o   // bad alignment or bad funct3 for this direction
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte picked by the full offset; halfword picked by offset bit 1
  assign byte_sel = rdata_i[{off_i, 3'b000} +: 8];
  assign half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o         = 4'hF;  // loads always fetch the whole word
    wdata_o      = rs2_i;
    ld_data_o    = '0;
    misaligned_o = 1'b0;

    case (funct3_i)
      F3_B: begin
        if (is_store_i) be_o = 4'b0001 << off_i;
        wdata_o   = {4{rs2_i[7:0]}};
        ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        misaligned_o = off_i[0];
        if (is_store_i) be_o = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{rs2_i[15:0]}};
        ld_data_o = {{16{half_sel[15]}}, half_sel};
      end
      F3_W: begin
        misaligned_o = (off_i != 2'b00);
        ld_data_o    = rdata_i;
      end
      F3_BU: begin
        ld_data_o = {24'h0, byte_sel};
      end
      F3_HU: begin
        misaligned_o = off_i[0];
        ld_data_o    = {16'h0, half_sel};
      end
      default: begin
        misaligned_o = 1'b1;
      end
    endcase

    // Unsigned encodings exist only for loads
    if (is_store_i && !f3_store_legal(funct3_i)) misaligned_o = 1'b1;
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage controller: turns load/store control into one req/ack data-bus transaction.
// Ports: clk/rst, M-stage controls in, dmem master interface, read_datam/stall/exceptions out.
// Latency: issue cycle + >=1 WAIT cycle stalled, then one unstalled DONE cycle.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255  // WAIT cycles without ack before bus_err, 1..255
)(
  input  logic                    clk,
  input  logic                    rst,          // synchronous, active-high
  input  logic                    memrd_sgnm,   // M-stage load
  input  logic                    memwr_sgnm,   // M-stage store (wins over load)
  input  logic [2:0]              funct3m,
  input  logic [31:0]             alu_resultm,  // effective byte address
  input  logic [31:0]             rd_final2m,   // store data (rs2)
  mem_stage_ctrl_if.master        dmem,
  output logic [31:0]             read_datam,   // extended load result to MEM/WB
  output logic                    stall_mem,    // freeze PC, IF/ID, ID/EX, EX/MEM
  output logic                    regwr_killm,  // gate regwr into MEM/WB
  output logic                    misalign_exc, // one-cycle pulse
  output logic                    bus_err       // one-cycle pulse on timeout
);

  // Counter value at which the final permitted WAIT cycle is running
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  mem_state_e       state_q;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [31:0]      read_datam_q;
  logic             misalign_q;
  logic             bus_err_q;
  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  logic             access;
  logic             timeout_hit;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata;
  logic [31:0]      al_ld;
  logic             al_mis;

  assign access      = memrd_sgnm | memwr_sgnm;
  assign cnt_d       = cnt_q + TMO_W'(1);
  assign timeout_hit = (cnt_q == TMO_LAST);

  // The aligner sees the live EX/MEM fields. They stay frozen while
  // stall_mem is high, so during WAIT they still describe the access
  // in flight and can be used to extend the returning read data.
  mem_align_unit u_align (
    .off_i        (alu_resultm[1:0]),
    .funct3_i     (funct3m),
    .is_store_i   (memwr_sgnm),
    .rs2_i        (rd_final2m),
    .rdata_i      (dmem.dmem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .ld_data_o    (al_ld),
    .misaligned_o (al_mis)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      read_datam_q <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (access) begin
            if (al_mis) begin
              // Trap without touching the bus; the instruction is not stalled
              misalign_q <= 1'b1;
            end else begin
              req_q   <= 1'b1;
              we_q    <= memwr_sgnm;
              addr_q  <= {alu_resultm[31:2], 2'b00};
              be_q    <= al_be;
              wdata_q <= al_wdata;
              cnt_q   <= '0;
              state_q <= WAIT;
            end
          end
        end

        WAIT: begin
          // An ack in the last permitted cycle still completes normally
          if (dmem.dmem_ack) begin
            req_q <= 1'b0;
            if (!we_q) read_datam_q <= al_ld;
            state_q <= DONE;
          end else if (timeout_hit) begin
            req_q        <= 1'b0;
            bus_err_q    <= 1'b1;
            read_datam_q <= '0;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        DONE: begin
          // Inputs still show the finished instruction; never reissue it
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall rises in the issue cycle itself so the EX/MEM register holds
  assign stall_mem   = ((state_q == IDLE) && access && !al_mis) || (state_q == WAIT);
  assign regwr_killm = stall_mem;

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  assign read_datam   = read_datam_q;
  assign misalign_exc = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed table, random traffic vs a model,
// and a reset-during-WAIT sequence. Inputs change and outputs are sampled on negedge.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memrd, memwr;
  logic [2:0]  f3;
  logic [31:0] addr, rs2;
  logic [31:0] read_datam;
  logic        stall, kill, mis_exc, berr;

  always #5 clk = ~clk;

  mem_stage_ctrl_if dmem_if ();

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .memrd_sgnm   (memrd),
    .memwr_sgnm   (memwr),
    .funct3m      (f3),
    .alu_resultm  (addr),
    .rd_final2m   (rs2),
    .dmem         (dmem_if),
    .read_datam   (read_datam),
    .stall_mem    (stall),
    .regwr_killm  (kill),
    .misalign_exc (mis_exc),
    .bus_err      (berr)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_rdm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference: access rules stated as sizes, masks and shifts
  function automatic void model(input logic wr, input logic [2:0] fn, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] rdat,
                                output logic mis, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] ld);
    int size, nb, off;
    logic [63:0] mask, raw, acc;
    size = int'(fn[1:0]);
    nb   = 1 << size;
    off  = int'(a[1:0]);
    mis  = (size == 3) || (fn[2] && size == 2) || (fn[2] && wr) || ((off % nb) != 0);
    be = 4'h0; wd = 32'h0; ld = 32'h0;
    if (mis) return;
    mask = (64'd1 << (nb * 8)) - 64'd1;
    be   = wr ? 4'(((1 << nb) - 1) << off) : 4'hF;
    acc  = 64'h0;
    for (int i = 0; i < 4; i += nb) acc |= (64'(d) & mask) << (i * 8);
    wd  = acc[31:0];
    raw = (64'(rdat) >> (off * 8)) & mask;
    if (!fn[2] && nb < 4 && raw[nb * 8 - 1]) raw |= ~mask;
    ld = raw[31:0];
  endfunction

  // Drives one M-stage instruction from IDLE back to IDLE.
  // ack_wait: WAIT cycle (1-based) carrying ack; 0 or > TO means no ack.
  task automatic run_txn(input string tag, input logic rd, input logic wr, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                         input int ack_wait, input logic e_mis, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic [31:0] e_rdm);
    int   waits;
    logic tmo;
    memrd = rd; memwr = wr; f3 = fn; addr = a; rs2 = d;
    #1;
    if (!rd && !wr) begin
      check({tag, ":idle_stall"}, 32'(stall), 32'd0);
      @(negedge clk);
      check({tag, ":idle_req"}, 32'(dmem_if.dmem_req), 32'd0);
      return;
    end
    check({tag, ":issue_stall"}, 32'(stall), 32'(!e_mis));
    check({tag, ":issue_kill"}, 32'(kill), 32'(!e_mis));
    if (e_mis) begin
      @(negedge clk);
      check({tag, ":mis_pulse"}, 32'(mis_exc), 32'd1);
      check({tag, ":mis_req"}, 32'(dmem_if.dmem_req), 32'd0);
      memrd = 1'b0; memwr = 1'b0;
      #1;
      check({tag, ":mis_stall"}, 32'(stall), 32'd0);
      @(negedge clk);
      check({tag, ":mis_pulse_end"}, 32'(mis_exc), 32'd0);
      check({tag, ":mis_rdm"}, read_datam, e_rdm);
      return;
    end
    waits = 0;
    tmo   = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      waits++;
      check({tag, ":wait_req"}, 32'(dmem_if.dmem_req), 32'd1);
      check({tag, ":wait_stall"}, 32'(stall), 32'd1);
      check({tag, ":addr"}, dmem_if.dmem_addr, a & 32'hFFFF_FFFC);
      check({tag, ":we"}, 32'(dmem_if.dmem_we), 32'(wr));
      check({tag, ":be"}, 32'(dmem_if.dmem_be), 32'(e_be));
      if (wr) check({tag, ":wdata"}, dmem_if.dmem_wdata, e_wd);
      check({tag, ":wait_buserr"}, 32'(berr), 32'd0);
      if (k == ack_wait) begin
        dmem_if.dmem_ack   = 1'b1;
        dmem_if.dmem_rdata = rdat;
        tmo = 1'b0;
        break;
      end
    end
    @(negedge clk);
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = $urandom;
    check({tag, ":done_stall"}, 32'(stall), 32'd0);
    check({tag, ":done_req"}, 32'(dmem_if.dmem_req), 32'd0);
    check({tag, ":done_buserr"}, 32'(berr), 32'(tmo));
    check({tag, ":done_rdm"}, read_datam, e_rdm);
    check({tag, ":wait_cycles"}, 32'(waits), tmo ? 32'(TO) : 32'(ack_wait));
    memrd = 1'b0; memwr = 1'b0;
    @(negedge clk);
    check({tag, ":idle_after_buserr"}, 32'(berr), 32'd0);
    check({tag, ":idle_after_stall"}, 32'(stall), 32'd0);
    check({tag, ":idle_after_req"}, 32'(dmem_if.dmem_req), 32'd0);
  endtask

  typedef struct {
    logic        rd, wr;
    logic [2:0]  fn;
    logic [31:0] a, d, rdat;
    int          ack_wait;
    logic        e_mis;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rdm;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // rd wr fn a d rdat ack mis be wdata read_datam
    tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 3, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
    tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 1, 1'b0, 4'hF, 32'h0,        32'hFFFFFF80};
    tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 1, 1'b0, 4'hF, 32'h0,        32'h00000080};
    tbl[3]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        1, 1'b0, 4'hC, 32'hABCDABCD, 32'h00000080};
    tbl[4]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        1, 1'b1, 4'h0, 32'h0,        32'h00000080};
    tbl[5]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1, 1'b1, 4'h0, 32'h0,        32'h00000080};
    tbl[6]  = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        1, 1'b1, 4'h0, 32'h0,        32'h00000080};
    tbl[7]  = '{1'b0, 1'b1, 3'b000, 32'h301, 32'h0000005A, 32'h0,        2, 1'b0, 4'h2, 32'h5A5A5A5A, 32'h00000080};
    tbl[8]  = '{1'b1, 1'b0, 3'b001, 32'h106, 32'h0,        32'h80017FFF, 1, 1'b0, 4'hF, 32'h0,        32'hFFFF8001};
    tbl[9]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'hFFFF9234, 2, 1'b0, 4'hF, 32'h0,        32'h00009234};
    tbl[10] = '{1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0,        1, 1'b0, 4'hF, 32'hCAFEF00D, 32'h00009234};
    tbl[11] = '{1'b1, 1'b0, 3'b001, 32'h103, 32'h0,        32'h0,        1, 1'b1, 4'h0, 32'h0,        32'h00009234};
    tbl[12] = '{1'b1, 1'b0, 3'b010, 32'h500, 32'h0,        32'h12345678, 0, 1'b0, 4'hF, 32'h0,        32'h00000000};
    tbl[13] = '{1'b1, 1'b1, 3'b010, 32'h404, 32'h11223344, 32'hFFFFFFFF, 4, 1'b0, 4'hF, 32'h11223344, 32'h00000000};
    tbl[14] = '{1'b0, 1'b1, 3'b000, 32'h007, 32'h000000A5, 32'h0,        1, 1'b0, 4'h8, 32'hA5A5A5A5, 32'h00000000};

    rst = 1'b1; memrd = 1'b0; memwr = 1'b0; f3 = 3'b000; addr = '0; rs2 = '0;
    dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst:req", 32'(dmem_if.dmem_req), 32'd0);
    check("rst:we", 32'(dmem_if.dmem_we), 32'd0);
    check("rst:addr", dmem_if.dmem_addr, 32'd0);
    check("rst:be", 32'(dmem_if.dmem_be), 32'd0);
    check("rst:wdata", dmem_if.dmem_wdata, 32'd0);
    check("rst:rdm", read_datam, 32'd0);
    check("rst:mis", 32'(mis_exc), 32'd0);
    check("rst:buserr", 32'(berr), 32'd0);
    check("rst:stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      run_txn($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].fn, tbl[i].a, tbl[i].d,
              tbl[i].rdat, tbl[i].ack_wait, tbl[i].e_mis, tbl[i].e_be, tbl[i].e_wd, tbl[i].e_rdm);
    end
    exp_rdm = 32'h0;

    for (int i = 0; i < 200; i++) begin
      logic        r_rd, r_wr, m_mis;
      logic [2:0]  r_fn;
      logic [31:0] r_a, r_d, r_rdat, m_wd, m_ld;
      logic [3:0]  m_be;
      int          sel, r_ack;
      sel    = $urandom_range(0, 7);
      r_rd   = (sel >= 1 && sel <= 3) || sel == 7;
      r_wr   = (sel >= 4);
      r_fn   = 3'($urandom_range(0, 7));
      r_a    = $urandom;
      if ($urandom_range(0, 1) == 0) r_a[1:0] = 2'b00;
      r_d    = $urandom;
      r_rdat = $urandom;
      r_ack  = $urandom_range(0, TO);
      model(r_wr, r_fn, r_a, r_d, r_rdat, m_mis, m_be, m_wd, m_ld);
      if ((r_rd || r_wr) && !m_mis) begin
        if (r_ack == 0) exp_rdm = 32'h0;
        else if (!r_wr) exp_rdm = m_ld;
      end
      run_txn($sformatf("rnd%0d", i), r_rd, r_wr, r_fn, r_a, r_d, r_rdat, r_ack,
              m_mis, m_be, m_wd, exp_rdm);
    end

    // Make read_datam non-zero so the reset clearing it is visible
    run_txn("pre_rst", 1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 32'h5555AAAA, 1,
            1'b0, 4'hF, 32'h0, 32'h5555AAAA);

    // Reset during WAIT, late ack must be ignored
    memrd = 1'b1; f3 = 3'b010; addr = 32'h600;
    @(negedge clk);
    check("rstw:req_w1", 32'(dmem_if.dmem_req), 32'd1);
    @(negedge clk);
    check("rstw:req_w2", 32'(dmem_if.dmem_req), 32'd1);
    rst = 1'b1; memrd = 1'b0;
    @(negedge clk);
    check("rstw:req", 32'(dmem_if.dmem_req), 32'd0);
    check("rstw:stall", 32'(stall), 32'd0);
    check("rstw:rdm", read_datam, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_if.dmem_ack = 1'b0;
    check("rstw:ack_rdm", read_datam, 32'd0);
    check("rstw:ack_req", 32'(dmem_if.dmem_req), 32'd0);
    check("rstw:ack_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("rstw:buserr", 32'(berr), 32'd0);
    check("rstw:rdm2", read_datam, 32'd0);
    check("rstw:stall2", 32'(stall), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller between the EX/MEM pipeline register and the MEM/WB register.
- Turns the M-stage load/store control into a req/ack data-memory bus transaction with byte-lane alignment, store-data replication and load extension.
- Produces read_datam for MEM/WB and a stall that freezes upstream stages while a transaction is outstanding.
- Reports misaligned/illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255, WAIT-state cycles without dmem_ack before bus_err; range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high
- memrd_sgnm  in  1  M-stage load
- memwr_sgnm  in  1  M-stage store
- funct3m  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- alu_resultm  in  32  effective byte address
- rd_final2m  in  32  store data (rs2)
- dmem_req  out  1  bus request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address {alu_resultm[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  one-cycle completion
- dmem_rdata  in  32  read word, valid with ack
- read_datam  out  32  extended load result to MEM/WB
- stall_mem  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- regwr_killm  out  1  gate regwr_sgnm into MEM/WB (=stall_mem)
- misalign_exc  out  1  one-cycle pulse, bad alignment or funct3
- bus_err  out  1  one-cycle pulse, timeout

Behaviour:
- Reset (synchronous, active-high): state=IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, read_datam, misalign_exc, bus_err, and the timeout counter all 0. Applies mid-transaction: req drops on the next edge, and a later ack is ignored.
- access = memrd_sgnm | memwr_sgnm. If both are set, the store wins (dmem_we=1).
- Misaligned cases:
  - halfword with addr[0]=1
  - word with addr[1:0]≠0
  - funct3 011/110/111, or LBU/LHU encodings on a store
- State IDLE:
  - access & misaligned: 1-cycle misalign_exc, no bus cycle, no stall; read_datam unchanged.
  - access & aligned: register dmem_req=1, we, addr, be, wdata; go to WAIT; counter=0.
  - stall_mem=1 combinationally in this cycle.
- State WAIT:
  - stall_mem=1; bus outputs held stable.
  - ack: dmem_req←0; on a load, read_datam←extend(dmem_rdata); go to DONE.
  - Otherwise the counter increments. When counter reaches TIMEOUT_CYCLES-1 without ack: req←0, bus_err pulse, read_datam←0, go to DONE.
- State DONE: stall_mem=0 for exactly one cycle so the instruction advances into MEM/WB; go to IDLE unconditionally. No reissue of the same instruction.
- Stores leave read_datam unchanged.
- Store lanes, with off=addr[1:0]:
  - SB: be=1<<off, wdata={4{rs2[7:0]}}
  - SH: be=off[1]?1100:0011, wdata={2{rs2[15:0]}}
  - SW: be=1111, wdata=rs2
- Load extract: select byte or half by off. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Loads drive be=1111.
- Best-case latency: issue cycle + 1 WAIT (ack) + DONE = 2 stall cycles.

Decomposition:
- Shared package (or include): funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU) and state encodings (IDLE, WAIT, DONE).
- One natural combinational sub-module, mem_align_unit: address offset + funct3 + rs2 + rdata in; be, wdata, extended load data and misaligned flag out. Reusable by a future instruction-fetch aligner.
- The FSM and timeout counter stay in mem_stage_ctrl.

Test Plan:
- LW at 0x100, ack after 3 cycles, rdata=0xDEADBEEF → req held 3 cycles, addr=0x100, be=1111; read_datam=0xDEADBEEF in DONE; stall high 4 cycles total.
- LB at 0x103, rdata=0x80FF_0000 → be=1111, read_datam=0xFFFFFF80. Same access as LBU → 0x00000080.
- SH at 0x202, rs2=0x1234ABCD, ack in 1 cycle → we=1, addr=0x200, be=1100, wdata=0xABCDABCD; read_datam unchanged.
- LW at 0x101 → misalign_exc one cycle, dmem_req never asserted, stall_mem stays 0. funct3=011 → same response.
- TIMEOUT_CYCLES=4, no ack → req held 4 WAIT cycles, then bus_err pulse, read_datam=0, one DONE cycle, back to IDLE.
- rst asserted during WAIT, then ack arrives 2 cycles later → state IDLE and req=0 after the reset edge; ack ignored; read_datam stays 0; no stall.
